fta_initiator64: RTL and testbench

- Single-outstanding FTA64 bus initiator: the requesting end of the FTA command/response protocol.
- Takes simple read/write commands from a local engine over a valid/ready handshake.
- Issues one fta_cmd_request64_t per command, matches the returning fta_cmd_response64_t by cid/tid, and hands read data or status back to the local engine.
- Sits between small control engines (boot sequencers, test drivers) and the FTA64 interconnect feeding peripheral responders.

---
 rtl/fta_bus_pkg.sv | 47 ++++
 rtl/fta_init_timer.sv | 30 +++
 rtl/fta_initiator64.sv | 199 +++++++++++++++++++
 tb/tb_fta_initiator64.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fta_bus_pkg.sv
// FTA64 bus package: request/response types, cycle-type encodings,
// initiator state encoding and a response-match helper.
package fta_bus_pkg;

  localparam int FTA_TID_W = 8;

  localparam logic [2:0] FTA_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] FTA_CTI_ERC     = 3'b001;

  // Default number of WAIT cycles before an initiator gives up.
  localparam int FTA_INIT_TIMEOUT_DEFAULT = 1023;

  typedef struct packed {
    logic                 cyc;
    logic                 we;
    logic [2:0]           cti;
    logic [3:0]           cid;
    logic [FTA_TID_W-1:0] tid;
    logic [7:0]           sel;
    logic [31:0]          padr;
    logic [63:0]          dat;
  } fta_cmd_request64_t;

  typedef struct packed {
    logic [3:0]           cid;
    logic [FTA_TID_W-1:0] tid;
    logic                 ack;
    logic                 err;
    logic                 rty;
    logic [63:0]          dat;
  } fta_cmd_response64_t;

  typedef enum logic [1:0] {
    FTA_INIT_IDLE  = 2'd0,
    FTA_INIT_ISSUE = 2'd1,
    FTA_INIT_WAIT  = 2'd2,
    FTA_INIT_DONE  = 2'd3
  } fta_init_state_t;

  // A response belongs to us when it carries any status bit and our cid/tid.
  function automatic logic fta_resp_match(input fta_cmd_response64_t r,
                                          input logic [3:0] cid,
                                          input logic [FTA_TID_W-1:0] tid);
    return (r.ack | r.err | r.rty) & (r.cid == cid) & (r.tid == tid);
  endfunction

endpackage

// File: rtl/fta_init_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module fta_init_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt_r;

  // Load on request, otherwise count down while enabled and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == '0);

endmodule

// File: rtl/fta_initiator64.sv
// Single-outstanding FTA64 initiator: one request per local command, response
// matched by cid/tid, completion strobed back to the local engine.
// Optional response timeout is built when FTA_INIT_TIMEOUT_EN is defined.
module fta_initiator64
  import fta_bus_pkg::*;
#(
  parameter logic [3:0] CID       = 4'd1,
  parameter logic       WR_ACK    = 1'b1,
  parameter int         MAX_RETRY = 3,
  parameter int         TIMEOUT   = FTA_INIT_TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [31:0]         cmd_adr,
  input  logic [7:0]          cmd_sel,
  input  logic [63:0]         cmd_dat,
  output logic                rsp_valid,
  output logic [63:0]         rsp_dat,
  output logic                rsp_err,
  output logic                busy,
  output fta_cmd_request64_t  req,
  input  fta_cmd_response64_t resp
);

  localparam logic [1:0] IDLE  = FTA_INIT_IDLE;
  localparam logic [1:0] ISSUE = FTA_INIT_ISSUE;
  localparam logic [1:0] WAIT  = FTA_INIT_WAIT;
  localparam logic [1:0] DONE  = FTA_INIT_DONE;

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [FTA_TID_W-1:0] TID_ONE   = FTA_TID_W'(1);
  localparam logic [RW-1:0]        RETRY_ONE = RW'(1);
  localparam logic [RW-1:0]        RETRY_MAX = RW'(MAX_RETRY);

  logic [1:0]           state_r, state_s;
  logic                 we_r, we_s;
  logic [31:0]          adr_r, adr_s;
  logic [7:0]           sel_r, sel_s;
  logic [63:0]          dat_r, dat_s;
  logic [FTA_TID_W-1:0] tid_r, tid_s;
  logic [RW-1:0]        retry_r, retry_s;
  logic                 err_r, err_s;
  logic                 cap_s;
  logic                 match_s;
  logic                 timeout_s;
  fta_cmd_request64_t   req_s;

`ifdef FTA_INIT_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic tmr_load_s;
  logic tmr_exp_s;

  // Restart the timer every time WAIT is entered (including after a retry).
  assign tmr_load_s = (state_s == WAIT) && (state_r != WAIT);
  assign timeout_s  = tmr_exp_s;

  fta_init_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (TW'(TIMEOUT - 1)),
    .en       (state_r == WAIT),
    .expired  (tmr_exp_s)
  );
`else
  // Without the timer, WAIT lasts until a matching response arrives.
  assign timeout_s = 1'b0;
`endif

  assign match_s = fta_resp_match(resp, CID, tid_r);

  // Next-state logic, command latching, retry accounting and completion status.
  always_comb begin
    state_s = state_r;
    we_s    = we_r;
    adr_s   = adr_r;
    sel_s   = sel_r;
    dat_s   = dat_r;
    tid_s   = tid_r;
    retry_s = retry_r;
    err_s   = err_r;
    cap_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_s = ISSUE;
          we_s    = cmd_we;
          adr_s   = cmd_adr;
          sel_s   = cmd_sel;
          dat_s   = cmd_dat;
          tid_s   = tid_r + TID_ONE;
          retry_s = '0;
          err_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (we_r && !WR_ACK) begin
          state_s = DONE;
          err_s   = 1'b0;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        // err beats rty beats ack when several arrive together.
        if (match_s && resp.err) begin
          state_s = DONE;
          err_s   = 1'b1;
        end else if (match_s && resp.rty) begin
          if (retry_r < RETRY_MAX) begin
            retry_s = retry_r + RETRY_ONE;
            state_s = ISSUE;
          end else begin
            state_s = DONE;
            err_s   = 1'b1;
          end
        end else if (match_s) begin
          state_s = DONE;
          err_s   = 1'b0;
          cap_s   = !we_r;
        end else if (timeout_s) begin
          state_s = DONE;
          err_s   = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
        retry_s = '0;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Request image for the ISSUE cycle, built from the values ISSUE will hold.
  always_comb begin
    req_s = '0;
    if (state_s == ISSUE) begin
      req_s.cyc  = 1'b1;
      req_s.we   = we_s;
      req_s.cti  = (we_s && WR_ACK) ? FTA_CTI_ERC : FTA_CTI_CLASSIC;
      req_s.cid  = CID;
      req_s.tid  = tid_s;
      req_s.sel  = sel_s;
      req_s.padr = adr_s;
      req_s.dat  = dat_s;
    end else begin
      req_s = '0;
    end
  end

  // State, latched command and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      we_r      <= 1'b0;
      adr_r     <= 32'd0;
      sel_r     <= 8'd0;
      dat_r     <= 64'd0;
      tid_r     <= '0;
      retry_r   <= '0;
      err_r     <= 1'b0;
      req       <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= 64'd0;
    end else begin
      state_r   <= state_s;
      we_r      <= we_s;
      adr_r     <= adr_s;
      sel_r     <= sel_s;
      dat_r     <= dat_s;
      tid_r     <= tid_s;
      retry_r   <= retry_s;
      err_r     <= err_s;
      req       <= req_s;
      cmd_ready <= (state_s == IDLE);
      busy      <= (state_s != IDLE);
      rsp_valid <= (state_r == DONE);
      rsp_err   <= (state_r == DONE) && err_r;
      if (cap_s) begin
        rsp_dat <= resp.dat;
      end else begin
        rsp_dat <= rsp_dat;
      end
    end
  end

endmodule

// File: tb/tb_fta_initiator64.sv
// Scoreboard bench for fta_initiator64: directed scenarios plus random
// commands against a transaction-level outcome model.
module tb_fta_initiator64;
  import fta_bus_pkg::*;

  localparam int MAXR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic cmd_valid, p_cmd_valid, cmd_we;
  logic [31:0] cmd_adr;
  logic [7:0]  cmd_sel;
  logic [63:0] cmd_dat;
  logic cmd_ready, rsp_valid, rsp_err, busy;
  logic [63:0] rsp_dat;
  fta_cmd_request64_t  req;
  fta_cmd_response64_t resp;
  logic p_cmd_ready, p_rsp_valid, p_rsp_err, p_busy;
  logic [63:0] p_rsp_dat;
  fta_cmd_request64_t  p_req;
  fta_cmd_response64_t p_resp;

  fta_initiator64 #(.CID(4'd1), .WR_ACK(1'b1), .MAX_RETRY(MAXR), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .busy(busy),
    .req(req), .resp(resp));

  fta_initiator64 #(.CID(4'd1), .WR_ACK(1'b0), .MAX_RETRY(MAXR), .TIMEOUT(16)) dutp (
    .clk(clk), .rst_n(rst_n), .cmd_valid(p_cmd_valid), .cmd_ready(p_cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
    .rsp_valid(p_rsp_valid), .rsp_dat(p_rsp_dat), .rsp_err(p_rsp_err), .busy(p_busy),
    .req(p_req), .resp(p_resp));

  typedef struct { logic err; logic [63:0] dat; } exp_t;
  exp_t q[$];
  exp_t pq[$];

  int total = 0;
  int bad = 0;
  logic [7:0]  exp_tid, p_tid;
  logic [63:0] model_dat, pmodel_dat;
  logic prev_cyc = 1'b0, p_prev_cyc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // Monitor: pop the scoreboard on every completion strobe.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 want none");
      end else begin : pop_main
        exp_t e;
        e = q.pop_front();
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_dat", rsp_dat, e.dat);
      end
    end
    if (p_rsp_valid === 1'b1) begin
      if (pq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_prsp: got rsp_valid=1 want none");
      end else begin : pop_post
        exp_t e;
        e = pq.pop_front();
        chk("p_rsp_err", p_rsp_err, e.err);
        chk("p_rsp_dat", p_rsp_dat, e.dat);
      end
    end
    if (req.cyc) chk("cyc_1clk", prev_cyc, 1'b0);
    if (p_req.cyc) chk("p_cyc_1clk", p_prev_cyc, 1'b0);
    prev_cyc = req.cyc;
    p_prev_cyc = p_req.cyc;
  end

  task automatic send(input bit p, input logic we, input logic [31:0] a,
                      input logic [7:0] s, input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    while (!(p ? p_cmd_ready : cmd_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready", p ? p_cmd_ready : cmd_ready, 1'b1);
    cmd_we = we; cmd_adr = a; cmd_sel = s; cmd_dat = d;
    if (p) p_cmd_valid = 1'b1; else cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    p_cmd_valid = 1'b0;
  endtask

  task automatic wait_cyc(input bit p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (p ? p_req.cyc : req.cyc) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("issue_seen", ok, 1'b1);
  endtask

  task automatic check_req(input bit p, input logic we, input logic [31:0] a,
                           input logic [7:0] s, input logic [63:0] d, input logic [7:0] t);
    fta_cmd_request64_t r;
    r = p ? p_req : req;
    chk("req_tid", r.tid, t);
    chk("req_cid", r.cid, 4'd1);
    chk("req_we", r.we, we);
    chk("req_padr", r.padr, a);
    chk("req_sel", r.sel, s);
    chk("req_dat", r.dat, d);
    chk("req_cti", r.cti, (we && !p) ? FTA_CTI_ERC : FTA_CTI_CLASSIC);
  endtask

  task automatic pulse(input bit a, input bit e, input bit r, input logic [7:0] t,
                       input logic [63:0] d);
    resp.ack = a; resp.err = e; resp.rty = r;
    resp.cid = 4'd1; resp.tid = t; resp.dat = d;
    @(negedge clk);
    resp = '0;
  endtask

  task automatic wait_rsp(input bit p, output int cnt);
    cnt = 0;
    while (!(p ? p_rsp_valid : rsp_valid) && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // One command on the acknowledged instance; outcome derived from the responder plan.
  task automatic do_cmd(input logic we, input logic [31:0] a, input logic [7:0] s,
                        input logic [63:0] d, input logic [63:0] rd, input int nrty,
                        input bit fin_err, input int dly, input bit wrong, input bit mix);
    exp_t e;
    int want_issues, issues, cnt;
    bit ok;
    exp_tid = exp_tid + 8'd1;
    if (nrty > MAXR) begin
      e.err = 1'b1; want_issues = MAXR + 1;
    end else if (fin_err) begin
      e.err = 1'b1; want_issues = nrty + 1;
    end else begin
      e.err = 1'b0; want_issues = nrty + 1;
      if (!we) model_dat = rd;
    end
    e.dat = model_dat;
    q.push_back(e);
    send(1'b0, we, a, s, d);
    issues = 0;
    for (int i = 0; i < want_issues; i++) begin
      wait_cyc(1'b0, ok);
      if (!ok) break;
      issues++;
      check_req(1'b0, we, a, s, d, exp_tid);
      @(negedge clk);
      repeat (dly) @(negedge clk);
      if (i < nrty) begin
        pulse(mix, 1'b0, 1'b1, exp_tid, rd);
      end else begin
        if (wrong) begin
          pulse(1'b1, 1'b0, 1'b0, exp_tid ^ 8'h5A, ~rd);
          @(negedge clk);
        end
        pulse(fin_err ? mix : 1'b1, fin_err, 1'b0, exp_tid, rd);
      end
    end
    chk("issue_count", issues, want_issues);
    wait_rsp(1'b0, cnt);
    chk("rsp_latency", cnt, 1);
  endtask

  task automatic posted(input logic [31:0] a, input logic [7:0] s, input logic [63:0] d);
    exp_t e;
    int cnt;
    bit ok;
    p_tid = p_tid + 8'd1;
    e.err = 1'b0; e.dat = pmodel_dat;
    pq.push_back(e);
    send(1'b1, 1'b1, a, s, d);
    wait_cyc(1'b1, ok);
    check_req(1'b1, 1'b1, a, s, d, p_tid);
    @(negedge clk);
    wait_rsp(1'b1, cnt);
    chk("posted_latency", cnt, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] old_tid;
    int cnt;
    bit ok;
    rst_n = 1'b0; cmd_valid = 1'b0; p_cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_adr = 32'd0; cmd_sel = 8'd0; cmd_dat = 64'd0; resp = '0; p_resp = '0;
    exp_tid = 8'd0; p_tid = 8'd0; model_dat = 64'd0; pmodel_dat = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_dat", rsp_dat, 64'd0);
    chk("rst_req_zero", req == '0, 1'b1);
    rst_n = 1'b1;

    do_cmd(1'b0, 32'h0000_1000, 8'hFF, 64'd0, 64'hDEAD_BEEF_0123_4567, 0, 1'b0, 3, 1'b0, 1'b0);
    do_cmd(1'b1, 32'h0000_2000, 8'h01, 64'hA5, 64'h1111_2222_3333_4444, 0, 1'b0, 1, 1'b0, 1'b0);
    posted(32'h0000_2000, 8'h01, 64'hA5);
    posted(32'h0000_3008, 8'hF0, 64'h0123_4567_89AB_CDEF);
    do_cmd(1'b0, 32'h0000_1008, 8'hFF, 64'd0, 64'hCAFE_F00D_0000_0001, 0, 1'b0, 0, 1'b1, 1'b0);
    do_cmd(1'b0, 32'h0000_1010, 8'hFF, 64'd0, 64'h5555_AAAA_5555_AAAA, 4, 1'b0, 0, 1'b0, 1'b0);
    do_cmd(1'b0, 32'h0000_1018, 8'h0F, 64'd0, 64'h7777_0000_7777_0000, 2, 1'b0, 1, 1'b0, 1'b1);
    do_cmd(1'b0, 32'h0000_1020, 8'hFF, 64'd0, 64'h9999_9999_9999_9999, 0, 1'b1, 0, 1'b0, 1'b1);

`ifdef FTA_INIT_TIMEOUT_EN
    begin : timeout_case
      exp_t e;
      exp_tid = exp_tid + 8'd1;
      e.err = 1'b1; e.dat = model_dat;
      q.push_back(e);
      send(1'b0, 1'b0, 32'h0000_4000, 8'hFF, 64'd0);
      wait_cyc(1'b0, ok);
      check_req(1'b0, 1'b0, 32'h0000_4000, 8'hFF, 64'd0, exp_tid);
      @(negedge clk);
      wait_rsp(1'b0, cnt);
      chk("timeout_latency", cnt, 17);
    end
    do_cmd(1'b0, 32'h0000_4008, 8'hFF, 64'd0, 64'h1234_0000_0000_4321, 0, 1'b0, 0, 1'b0, 1'b0);
`endif

    // Reset during WAIT: abandon the read, then feed a stale ack.
    exp_tid = exp_tid + 8'd1;
    send(1'b0, 1'b0, 32'h0000_5000, 8'hFF, 64'd0);
    wait_cyc(1'b0, ok);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_req_zero", req == '0, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cmd_ready", cmd_ready, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_rsp_err", rsp_err, 1'b0);
    chk("arst_rsp_dat", rsp_dat, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    old_tid = exp_tid;
    exp_tid = 8'd0; p_tid = 8'd0; model_dat = 64'd0; pmodel_dat = 64'd0;
    pulse(1'b1, 1'b0, 1'b0, old_tid, 64'hBAD0_BAD0_BAD0_BAD0);
    pulse(1'b1, 1'b0, 1'b0, 8'd0, 64'hBAD1_BAD1_BAD1_BAD1);
    repeat (6) @(negedge clk);
    chk("stale_busy", busy, 1'b0);
    chk("stale_rsp_dat", rsp_dat, 64'd0);

    for (int k = 0; k < 30; k++) begin
      do_cmd(1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 255)),
             {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 4),
             ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    posted($urandom, 8'hFF, {$urandom, $urandom});

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size() + pq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
